// File: rtl/io_load_request_controller_if.sv
// Handshake and bus bundle for the IO load request controller.
// master = controller side, slave = dispatch/bus/writeback side.
interface io_load_request_controller_if #(
  parameter int DATABITWIDTH    = 16,
  parameter int REGADDRBITWIDTH = 4
);
  logic                       LoadReq_Valid;
  logic                       LoadReq_Ready;
  logic [3:0]                 LoadReq_MinorOpcode;
  logic [DATABITWIDTH-1:0]    LoadReq_Addr;
  logic [REGADDRBITWIDTH-1:0] LoadReq_DestReg;

  logic                       IOBus_ReqValid;
  logic                       IOBus_ReqReady;
  logic [DATABITWIDTH-1:0]    IOBus_ReqAddr;
  logic                       IOBus_RespValid;
  logic [DATABITWIDTH-1:0]    IOBus_RespData;

  logic [3:0]                 Align_MinorOpcode;
  logic [DATABITWIDTH-1:0]    Align_DataAddr;
  logic [DATABITWIDTH-1:0]    Align_Data;

  logic                       Writeback_Valid;
  logic                       Writeback_Ready;
  logic [REGADDRBITWIDTH-1:0] Writeback_DestReg;
  logic                       Timeout_Error;

  modport master (
    input  LoadReq_Valid, LoadReq_MinorOpcode, LoadReq_Addr, LoadReq_DestReg,
    input  IOBus_ReqReady, IOBus_RespValid, IOBus_RespData, Writeback_Ready,
    output LoadReq_Ready, IOBus_ReqValid, IOBus_ReqAddr,
    output Align_MinorOpcode, Align_DataAddr, Align_Data,
    output Writeback_Valid, Writeback_DestReg, Timeout_Error
  );

  modport slave (
    output LoadReq_Valid, LoadReq_MinorOpcode, LoadReq_Addr, LoadReq_DestReg,
    output IOBus_ReqReady, IOBus_RespValid, IOBus_RespData, Writeback_Ready,
    input  LoadReq_Ready, IOBus_ReqValid, IOBus_ReqAddr,
    input  Align_MinorOpcode, Align_DataAddr, Align_Data,
    input  Writeback_Valid, Writeback_DestReg, Timeout_Error
  );
endinterface

// File: rtl/io_load_request_controller.sv
// Single-outstanding IO load controller: accept, word-aligned bus read, hold result for writeback.
// Optional response timeout and stale-response filtering enabled by macro IO_LOAD_TIMEOUT_EN.
module io_load_request_controller #(
  parameter int DATABITWIDTH    = 16,
  parameter int REGADDRBITWIDTH = 4,
  parameter int TIMEOUTBITWIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clk_en,
  io_load_request_controller_if.master bus
);

  localparam int ADDRLSB = $clog2(DATABITWIDTH / 8);
  localparam logic [DATABITWIDTH-1:0] ADDRMASK = ~DATABITWIDTH'((64'd1 << ADDRLSB) - 64'd1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAITRESP, HOLD} stateT;

  stateT                      stateQ, stateD;
  logic                       accept, respTake, timeoutTake;
  logic                       staleQ, timeoutHit;
  logic [3:0]                 opcodeQ;
  logic [DATABITWIDTH-1:0]    addrQ;
  logic [REGADDRBITWIDTH-1:0] destRegQ;
  logic [DATABITWIDTH-1:0]    dataQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      stateQ <= IDLE;
    else if (clk_en) stateQ <= stateD;
  end

  // Every event below is qualified with clk_en so the datapath needs no extra gating.
  always_comb begin
    stateD             = stateQ;
    accept             = 1'b0;
    respTake           = 1'b0;
    timeoutTake        = 1'b0;
    bus.LoadReq_Ready  = 1'b0;
    bus.IOBus_ReqValid = 1'b0;
    bus.Writeback_Valid = 1'b0;
    case (stateQ)
      IDLE: begin
        bus.LoadReq_Ready = !staleQ;
        if (clk_en && bus.LoadReq_Valid && !staleQ) begin
          accept = 1'b1;
          stateD = ISSUE;
        end
      end
      ISSUE: begin
        bus.IOBus_ReqValid = 1'b1;
        if (clk_en && bus.IOBus_ReqReady) stateD = WAITRESP;
      end
      WAITRESP: begin
        if (clk_en) begin
          if (bus.IOBus_RespValid) begin
            respTake = 1'b1;
            stateD   = HOLD;
          end else if (timeoutHit) begin
            timeoutTake = 1'b1;
            stateD      = HOLD;
          end
        end
      end
      HOLD: begin
        bus.Writeback_Valid = 1'b1;
        if (clk_en && bus.Writeback_Ready) stateD = IDLE;
      end
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcodeQ  <= '0;
      addrQ    <= '0;
      destRegQ <= '0;
      dataQ    <= '0;
    end else begin
      if (accept) begin
        opcodeQ  <= bus.LoadReq_MinorOpcode;
        addrQ    <= bus.LoadReq_Addr;
        destRegQ <= bus.LoadReq_DestReg;
      end
      if (respTake)         dataQ <= bus.IOBus_RespData;
      else if (timeoutTake) dataQ <= '0;
    end
  end

`ifdef IO_LOAD_TIMEOUT_EN
  logic [TIMEOUTBITWIDTH-1:0] cntQ;
  logic                       timeoutErrQ;

  // Expire on the WAIT cycle that would take the counter from 1 to 0.
  assign timeoutHit = (cntQ == TIMEOUTBITWIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cntQ        <= '0;
      staleQ      <= 1'b0;
      timeoutErrQ <= 1'b0;
    end else if (clk_en) begin
      if (stateQ == ISSUE && bus.IOBus_ReqReady)
        cntQ <= '1;
      else if (stateQ == WAITRESP && !bus.IOBus_RespValid)
        cntQ <= cntQ - TIMEOUTBITWIDTH'(1);

      // A timed-out read may still answer later; that answer only clears the flag.
      if (timeoutTake)
        staleQ <= 1'b1;
      else if (stateQ != WAITRESP && bus.IOBus_RespValid)
        staleQ <= 1'b0;

      if (respTake)         timeoutErrQ <= 1'b0;
      else if (timeoutTake) timeoutErrQ <= 1'b1;
    end
  end

  assign bus.Timeout_Error = timeoutErrQ;
`else
  logic unusedTimeoutCfg;

  assign staleQ            = 1'b0;
  assign timeoutHit        = 1'b0;
  assign bus.Timeout_Error = 1'b0;
  assign unusedTimeoutCfg  = (TIMEOUTBITWIDTH > 0);
`endif

  assign bus.IOBus_ReqAddr       = addrQ & ADDRMASK;
  assign bus.Align_MinorOpcode   = opcodeQ;
  assign bus.Align_DataAddr      = addrQ;
  assign bus.Align_Data          = dataQ;
  assign bus.Writeback_DestReg   = destRegQ;

endmodule

// File: tb/tb_io_load_request_controller.sv
// Directed bench for io_load_request_controller: 16-bit instance (4-bit timeout) and 32-bit instance.
// Timeout/stale sequence runs only when IO_LOAD_TIMEOUT_EN is defined.
module tb_io_load_request_controller;

  logic clk = 1'b0;
  logic rst_n;
  logic clk_en;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  io_load_request_controller_if #(.DATABITWIDTH(16), .REGADDRBITWIDTH(4)) ifc16 ();
  io_load_request_controller_if #(.DATABITWIDTH(32), .REGADDRBITWIDTH(4)) ifc32 ();

  io_load_request_controller #(
    .DATABITWIDTH(16), .REGADDRBITWIDTH(4), .TIMEOUTBITWIDTH(4)
  ) dut16 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .bus(ifc16)
  );

  io_load_request_controller #(
    .DATABITWIDTH(32), .REGADDRBITWIDTH(4), .TIMEOUTBITWIDTH(8)
  ) dut32 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .bus(ifc32)
  );

  typedef struct {
    logic [3:0]  op;
    logic [15:0] addr;
    logic [3:0]  dest;
    logic [15:0] rdata;
    logic [15:0] busAddr;
  } vecT;

  vecT vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic req16(input logic [3:0] op, input logic [15:0] a, input logic [3:0] d);
    chk("idle_ready", 64'(ifc16.LoadReq_Ready), 64'd1);
    ifc16.LoadReq_Valid       = 1'b1;
    ifc16.LoadReq_MinorOpcode = op;
    ifc16.LoadReq_Addr        = a;
    ifc16.LoadReq_DestReg     = d;
    tick();
    ifc16.LoadReq_Valid       = 1'b0;
  endtask

  task automatic issue16(input logic [15:0] expAddr);
    chk("issue_reqvalid", 64'(ifc16.IOBus_ReqValid), 64'd1);
    chk("issue_reqaddr", 64'(ifc16.IOBus_ReqAddr), 64'(expAddr));
    ifc16.IOBus_ReqReady = 1'b1;
    tick();
    ifc16.IOBus_ReqReady = 1'b0;
    chk("wait_reqvalid", 64'(ifc16.IOBus_ReqValid), 64'd0);
    chk("wait_wbvalid", 64'(ifc16.Writeback_Valid), 64'd0);
  endtask

  task automatic resp16(input logic [15:0] data);
    ifc16.IOBus_RespValid = 1'b1;
    ifc16.IOBus_RespData  = data;
    tick();
    ifc16.IOBus_RespValid = 1'b0;
  endtask

  task automatic hold16(input logic [3:0] op, input logic [15:0] a, input logic [3:0] d,
                        input logic [15:0] data, input logic terr);
    chk("hold_wbvalid", 64'(ifc16.Writeback_Valid), 64'd1);
    chk("hold_data", 64'(ifc16.Align_Data), 64'(data));
    chk("hold_addr", 64'(ifc16.Align_DataAddr), 64'(a));
    chk("hold_opcode", 64'(ifc16.Align_MinorOpcode), 64'(op));
    chk("hold_destreg", 64'(ifc16.Writeback_DestReg), 64'(d));
    chk("hold_timeout", 64'(ifc16.Timeout_Error), 64'(terr));
    chk("hold_ldready", 64'(ifc16.LoadReq_Ready), 64'd0);
  endtask

  task automatic release16(input logic expReady);
    ifc16.Writeback_Ready = 1'b1;
    tick();
    ifc16.Writeback_Ready = 1'b0;
    chk("release_wbvalid", 64'(ifc16.Writeback_Valid), 64'd0);
    chk("release_ldready", 64'(ifc16.LoadReq_Ready), 64'(expReady));
  endtask

  task automatic runVec(input vecT v);
    req16(v.op, v.addr, v.dest);
    issue16(v.busAddr);
    resp16(v.rdata);
    hold16(v.op, v.addr, v.dest, v.rdata, 1'b0);
    release16(1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{op: 4'h0, addr: 16'h0013, dest: 4'h5, rdata: 16'hBEEF, busAddr: 16'h0012};
    vecs[1] = '{op: 4'h1, addr: 16'h1234, dest: 4'hA, rdata: 16'h5A5A, busAddr: 16'h1234};
    vecs[2] = '{op: 4'h2, addr: 16'hFFFF, dest: 4'hF, rdata: 16'h0001, busAddr: 16'hFFFE};
    vecs[3] = '{op: 4'hB, addr: 16'h0000, dest: 4'h0, rdata: 16'hFFFF, busAddr: 16'h0000};

    {ifc16.LoadReq_Valid, ifc16.IOBus_ReqReady, ifc16.IOBus_RespValid, ifc16.Writeback_Ready} = '0;
    ifc16.LoadReq_MinorOpcode = '0; ifc16.LoadReq_Addr = '0; ifc16.LoadReq_DestReg = '0;
    ifc16.IOBus_RespData = '0;
    {ifc32.LoadReq_Valid, ifc32.IOBus_ReqReady, ifc32.IOBus_RespValid, ifc32.Writeback_Ready} = '0;
    ifc32.LoadReq_MinorOpcode = '0; ifc32.LoadReq_Addr = '0; ifc32.LoadReq_DestReg = '0;
    ifc32.IOBus_RespData = '0;
    clk_en = 1'b1;
    rst_n  = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ldready", 64'(ifc16.LoadReq_Ready), 64'd1);
    chk("rst_reqvalid", 64'(ifc16.IOBus_ReqValid), 64'd0);
    chk("rst_wbvalid", 64'(ifc16.Writeback_Valid), 64'd0);
    chk("rst_timeout", 64'(ifc16.Timeout_Error), 64'd0);
    chk("rst_data", 64'(ifc16.Align_Data), 64'd0);
    chk("rst_addr", 64'(ifc16.Align_DataAddr), 64'd0);
    chk("rst_destreg", 64'(ifc16.Writeback_DestReg), 64'd0);
    chk("rst_reqaddr", 64'(ifc16.IOBus_ReqAddr), 64'd0);
    chk("rst_ldready32", 64'(ifc32.LoadReq_Ready), 64'd1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) runVec(vecs[i]);

    // 32-bit: request stalled by the bus for three cycles
    ifc32.LoadReq_Valid = 1'b1; ifc32.LoadReq_MinorOpcode = 4'h1;
    ifc32.LoadReq_Addr  = 32'h0000_0106; ifc32.LoadReq_DestReg = 4'h3;
    tick();
    ifc32.LoadReq_Valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("w32_stall_reqvalid", 64'(ifc32.IOBus_ReqValid), 64'd1);
      chk("w32_stall_reqaddr", 64'(ifc32.IOBus_ReqAddr), 64'h0000_0104);
      tick();
    end
    chk("w32_reqvalid", 64'(ifc32.IOBus_ReqValid), 64'd1);
    ifc32.IOBus_ReqReady = 1'b1;
    tick();
    ifc32.IOBus_ReqReady = 1'b0;
    chk("w32_wait_reqvalid", 64'(ifc32.IOBus_ReqValid), 64'd0);
    chk("w32_wait_wbvalid", 64'(ifc32.Writeback_Valid), 64'd0);
    ifc32.IOBus_RespValid = 1'b1; ifc32.IOBus_RespData = 32'hCAFE_F00D;
    tick();
    ifc32.IOBus_RespValid = 1'b0;
    chk("w32_wbvalid", 64'(ifc32.Writeback_Valid), 64'd1);
    chk("w32_data", 64'(ifc32.Align_Data), 64'hCAFE_F00D);
    chk("w32_addr", 64'(ifc32.Align_DataAddr), 64'h0000_0106);
    chk("w32_destreg", 64'(ifc32.Writeback_DestReg), 64'd3);
    ifc32.Writeback_Ready = 1'b1;
    tick();
    ifc32.Writeback_Ready = 1'b0;
    chk("w32_release_wbvalid", 64'(ifc32.Writeback_Valid), 64'd0);
    chk("w32_release_ldready", 64'(ifc32.LoadReq_Ready), 64'd1);

    // writeback back-pressure with a second request waiting
    req16(4'h3, 16'h0022, 4'h4);
    issue16(16'h0022);
    resp16(16'h9876);
    ifc16.LoadReq_Valid = 1'b1; ifc16.LoadReq_MinorOpcode = 4'h1;
    ifc16.LoadReq_Addr  = 16'h0040; ifc16.LoadReq_DestReg = 4'hC;
    hold16(4'h3, 16'h0022, 4'h4, 16'h9876, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      hold16(4'h3, 16'h0022, 4'h4, 16'h9876, 1'b0);
    end
    ifc16.Writeback_Ready = 1'b1;
    tick();
    ifc16.Writeback_Ready = 1'b0;
    chk("bp_idle_wbvalid", 64'(ifc16.Writeback_Valid), 64'd0);
    chk("bp_idle_reqvalid", 64'(ifc16.IOBus_ReqValid), 64'd0);
    chk("bp_idle_ldready", 64'(ifc16.LoadReq_Ready), 64'd1);
    chk("bp_idle_addr_held", 64'(ifc16.Align_DataAddr), 64'h0022);
    tick();
    ifc16.LoadReq_Valid = 1'b0;
    issue16(16'h0040);
    resp16(16'h0F0F);
    hold16(4'h1, 16'h0040, 4'hC, 16'h0F0F, 1'b0);
    release16(1'b1);

    // clock-enable freeze in ISSUE and WAIT
    req16(4'h2, 16'h0500, 4'h9);
    ifc16.IOBus_ReqReady = 1'b1;
    clk_en = 1'b0;
    tick();
    tick();
    chk("freeze_issue_reqvalid", 64'(ifc16.IOBus_ReqValid), 64'd1);
    clk_en = 1'b1;
    ifc16.IOBus_ReqReady = 1'b0;
    issue16(16'h0500);
    clk_en = 1'b0;
    ifc16.Writeback_Ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("freeze_wait_wbvalid", 64'(ifc16.Writeback_Valid), 64'd0);
    ifc16.Writeback_Ready = 1'b0;
    clk_en = 1'b1;
    for (int i = 0; i < 13; i++) tick();
    chk("freeze_prersp_wbvalid", 64'(ifc16.Writeback_Valid), 64'd0);
    resp16(16'h7E57);
    hold16(4'h2, 16'h0500, 4'h9, 16'h7E57, 1'b0);
    release16(1'b1);

`ifdef IO_LOAD_TIMEOUT_EN
    // no response: 15 WAIT cycles then a timeout result; late answer discarded
    req16(4'h1, 16'h0200, 4'h7);
    issue16(16'h0200);
    for (int i = 0; i < 14; i++) tick();
    chk("to_before_expiry", 64'(ifc16.Writeback_Valid), 64'd0);
    tick();
    hold16(4'h1, 16'h0200, 4'h7, 16'h0000, 1'b1);
    release16(1'b0);
    ifc16.LoadReq_Valid = 1'b1; ifc16.LoadReq_Addr = 16'h0300;
    tick();
    chk("to_stale_noaccept", 64'(ifc16.IOBus_ReqValid), 64'd0);
    chk("to_stale_ldready", 64'(ifc16.LoadReq_Ready), 64'd0);
    ifc16.LoadReq_Valid = 1'b0;
    resp16(16'h1111);
    chk("to_late_ldready", 64'(ifc16.LoadReq_Ready), 64'd1);
    chk("to_late_discard", 64'(ifc16.Align_Data), 64'd0);
    chk("to_late_wbvalid", 64'(ifc16.Writeback_Valid), 64'd0);
`endif

    // asynchronous reset in WAIT, then a stray response and a clean transaction
    req16(4'h1, 16'h0ABC, 4'h6);
    issue16(16'h0ABC);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ldready", 64'(ifc16.LoadReq_Ready), 64'd1);
    chk("arst_reqvalid", 64'(ifc16.IOBus_ReqValid), 64'd0);
    chk("arst_wbvalid", 64'(ifc16.Writeback_Valid), 64'd0);
    chk("arst_timeout", 64'(ifc16.Timeout_Error), 64'd0);
    chk("arst_addr", 64'(ifc16.Align_DataAddr), 64'd0);
    chk("arst_destreg", 64'(ifc16.Writeback_DestReg), 64'd0);
    chk("arst_data", 64'(ifc16.Align_Data), 64'd0);
    #1 rst_n = 1'b1;
    tick();
    resp16(16'h2222);
    chk("stray_ldready", 64'(ifc16.LoadReq_Ready), 64'd1);
    chk("stray_wbvalid", 64'(ifc16.Writeback_Valid), 64'd0);
    chk("stray_reqvalid", 64'(ifc16.IOBus_ReqValid), 64'd0);
    chk("stray_data", 64'(ifc16.Align_Data), 64'd0);
    runVec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
